// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N:1 channel mux with manual select and a
// dwell-timed round-robin scan mode that pulses wrap on return to channel 0.
//
// Ports:
//   clk      in   1               rising-edge clock
//   rst      in   1               asynchronous active-high reset
//   din      in   CHANNELS*WIDTH  packed channel data, channel k at din[k*WIDTH +: WIDTH]
//   sel      in   SEL_W           manual select / scan restart channel on load
//   mode     in   1               0 = manual, 1 = scan
//   load     in   1               scan restart strobe (ignored in manual)
//   y        out  WIDTH           registered selected channel data
//   y_valid  out  1               y came from a legal channel
//   cur_sel  out  SEL_W           channel that produced y
//   wrap     out  1               one-cycle pulse on scan wrap to channel 0
module chan_scan_mux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      load,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
    localparam int unsigned NCH = CHANNELS;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t              r_st;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_y;
    logic                r_valid;
    logic [SEL_W-1:0]    r_cur_sel;
    logic                r_wrap;

    state_t              w_st_next;
    logic [CW-1:0]       w_cnt_next;
    logic [WIDTH-1:0]    w_y_next;
    logic                w_valid_next;
    logic [SEL_W-1:0]    w_sel_next;
    logic                w_wrap_next;
    logic [WIDTH-1:0]    w_mux;
    logic                w_sel_legal;
    logic                w_cur_legal;

    assign w_sel_legal = (32'(sel) < NCH);
    assign w_cur_legal = (32'(r_cur_sel) < NCH);

    // Data is taken from the channel that cur_sel will show after this
    // edge, so y and cur_sel always move together.
    always_comb begin
        w_mux = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_sel_next == SEL_W'(k)) begin
                w_mux = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st <= ST_MANUAL;
        end else begin
            r_st <= w_st_next;
        end
    end

    always_comb begin
        w_st_next    = mode ? ST_SCAN : ST_MANUAL;
        w_sel_next   = r_cur_sel;
        w_cnt_next   = '0;
        w_wrap_next  = 1'b0;
        w_valid_next = 1'b0;
        unique case (w_st_next)
            ST_MANUAL: begin
                w_sel_next   = sel;
                w_valid_next = w_sel_legal;
            end
            ST_SCAN: begin
                w_valid_next = 1'b1;
                if (load && w_sel_legal) begin
                    w_sel_next = sel;
                end else if (r_st == ST_MANUAL && !w_cur_legal) begin
                    // Entering scan from an illegal manual select.
                    w_sel_next = '0;
                end else if (r_cnt == CNT_LAST) begin
                    if (r_cur_sel == SEL_LAST) begin
                        w_sel_next  = '0;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_sel_next = r_cur_sel + SEL_W'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_valid_next = 1'b0;
            end
        endcase
        w_y_next = w_valid_next ? w_mux : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_cur_sel <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_y       <= w_y_next;
            r_valid   <= w_valid_next;
            r_cur_sel <= w_sel_next;
            r_wrap    <= w_wrap_next;
        end
    end

    assign y       = r_y;
    assign y_valid = r_valid;
    assign cur_sel = r_cur_sel;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed bench for chan_scan_mux in three configurations
// (8ch/dwell 4, 6ch with illegal selects, 3ch/dwell 1).
module tb_chan_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]  a_din;
    logic [2:0]  a_sel;
    logic        a_mode, a_load;
    logic        a_y, a_valid, a_wrap;
    logic [2:0]  a_cur;

    logic [23:0] b_din;
    logic [2:0]  b_sel;
    logic        b_mode, b_load;
    logic [3:0]  b_y;
    logic        b_valid, b_wrap;
    logic [2:0]  b_cur;

    logic [5:0]  c_din;
    logic [1:0]  c_sel;
    logic        c_mode, c_load;
    logic [1:0]  c_y;
    logic        c_valid, c_wrap;
    logic [1:0]  c_cur;

    int n_checks = 0;
    int n_fail   = 0;

    chan_scan_mux #(.WIDTH(1), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .sel(a_sel), .mode(a_mode),
        .load(a_load), .y(a_y), .y_valid(a_valid), .cur_sel(a_cur),
        .wrap(a_wrap)
    );

    chan_scan_mux #(.WIDTH(4), .CHANNELS(6), .SEL_W(3), .DWELL(4)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .sel(b_sel), .mode(b_mode),
        .load(b_load), .y(b_y), .y_valid(b_valid), .cur_sel(b_cur),
        .wrap(b_wrap)
    );

    chan_scan_mux #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut_c (
        .clk(clk), .rst(rst), .din(c_din), .sel(c_sel), .mode(c_mode),
        .load(c_load), .y(c_y), .y_valid(c_valid), .cur_sel(c_cur),
        .wrap(c_wrap)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_checks++;
        if (a_y !== 1'b0 || a_valid !== 1'b0 || a_cur !== 3'd0 || a_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: y=%b v=%b cur=%0d wrap=%b want all 0", a_y, a_valid, a_cur, a_wrap);
        end
        n_checks++;
        if (b_y !== 4'd0 || b_valid !== 1'b0 || b_cur !== 3'd0 || b_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: y=%0d v=%b cur=%0d wrap=%b want all 0", b_y, b_valid, b_cur, b_wrap);
        end
        tick();
        n_checks++;
        if (a_valid !== 1'b0 || c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: a_v=%b c_v=%b want 0 0", a_valid, c_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_manual_sweep;
        logic exp_y;
        a_mode = 1'b0;
        a_din  = 8'b1010_1010;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_sel = 3'(i);
            tick();
            exp_y = (i % 2 == 1);
            n_checks++;
            if (a_y !== exp_y) begin
                n_fail++;
                $display("FAIL manual_y[%0d]: got %b want %b", i, a_y, exp_y);
            end
            n_checks++;
            if (a_valid !== 1'b1 || a_cur !== 3'(i)) begin
                n_fail++;
                $display("FAIL manual_sel[%0d]: v=%b cur=%0d want v=1 cur=%0d", i, a_valid, a_cur, i);
            end
        end
    endtask

    task automatic test_scan_dwell;
        logic [2:0] exp_sel;
        logic       exp_wrap;
        logic       exp_y;
        a_mode = 1'b1;
        a_load = 1'b0;
        a_din  = 8'b1100_1010;
        do_reset();
        for (int e = 1; e <= 36; e++) begin
            if (e >= 20) a_din = 8'b0011_0101;
            tick();
            exp_sel  = 3'((e / 4) % 8);
            exp_wrap = (e % 32 == 0);
            exp_y    = a_din[exp_sel];
            n_checks++;
            if (a_cur !== exp_sel || a_wrap !== exp_wrap) begin
                n_fail++;
                $display("FAIL scan_sel[%0d]: cur=%0d wrap=%b want cur=%0d wrap=%b", e, a_cur, a_wrap, exp_sel, exp_wrap);
            end
            n_checks++;
            if (a_y !== exp_y || a_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_y[%0d]: y=%b v=%b want y=%b v=1", e, a_y, a_valid, exp_y);
            end
        end
    endtask

    task automatic test_load_collision;
        logic [2:0] exp_sel;
        a_mode = 1'b1;
        a_load = 1'b0;
        a_din  = 8'b0000_0100;
        do_reset();
        for (int e = 1; e <= 31; e++) tick();
        n_checks++;
        if (a_cur !== 3'd7) begin
            n_fail++;
            $display("FAIL collide_setup: cur=%0d want 7", a_cur);
        end
        a_load = 1'b1;
        a_sel  = 3'd2;
        tick();
        a_load = 1'b0;
        a_sel  = 3'd0;
        n_checks++;
        if (a_cur !== 3'd2 || a_wrap !== 1'b0 || a_y !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_load: cur=%0d wrap=%b y=%b want cur=2 wrap=0 y=1", a_cur, a_wrap, a_y);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_sel = (k < 4) ? 3'd2 : 3'd3;
            n_checks++;
            if (a_cur !== exp_sel || a_wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL collide_hold[%0d]: cur=%0d wrap=%b want cur=%0d wrap=0", k, a_cur, a_wrap, exp_sel);
            end
        end
    endtask

    task automatic test_illegal_select;
        b_din  = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        b_mode = 1'b0;
        b_load = 1'b0;
        b_sel  = 3'd7;
        do_reset();
        tick();
        n_checks++;
        if (b_y !== 4'd0 || b_valid !== 1'b0 || b_cur !== 3'd7) begin
            n_fail++;
            $display("FAIL illegal_manual7: y=%0d v=%b cur=%0d want 0 0 7", b_y, b_valid, b_cur);
        end
        b_sel = 3'd6;
        tick();
        n_checks++;
        if (b_y !== 4'd0 || b_valid !== 1'b0 || b_cur !== 3'd6) begin
            n_fail++;
            $display("FAIL illegal_manual6: y=%0d v=%b cur=%0d want 0 0 6", b_y, b_valid, b_cur);
        end
        b_sel = 3'd5;
        tick();
        n_checks++;
        if (b_y !== 4'h6 || b_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL legal_manual5: y=%0d v=%b want 6 1", b_y, b_valid);
        end
        b_sel = 3'd7;
        tick();
        b_mode = 1'b1;
        tick();
        n_checks++;
        if (b_cur !== 3'd0 || b_valid !== 1'b1 || b_y !== 4'h1 || b_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_enter_scan: cur=%0d v=%b y=%0d wrap=%b want 0 1 1 0", b_cur, b_valid, b_y, b_wrap);
        end
        b_load = 1'b1;
        b_sel  = 3'd6;
        tick();
        b_load = 1'b0;
        n_checks++;
        if (b_cur !== 3'd0 || b_y !== 4'h1) begin
            n_fail++;
            $display("FAIL illegal_load: cur=%0d y=%0d want 0 1", b_cur, b_y);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (b_cur !== 3'd1 || b_y !== 4'h2) begin
            n_fail++;
            $display("FAIL illegal_advance: cur=%0d y=%0d want 1 2", b_cur, b_y);
        end
        b_mode = 1'b0;
        b_sel  = 3'd0;
    endtask

    task automatic test_async_reset;
        logic [2:0] exp_sel;
        a_mode = 1'b1;
        a_load = 1'b0;
        a_din  = 8'hFF;
        do_reset();
        for (int e = 1; e <= 20; e++) tick();
        n_checks++;
        if (a_cur !== 3'd5 || a_y !== 1'b1 || a_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: cur=%0d y=%b v=%b want 5 1 1", a_cur, a_y, a_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_y !== 1'b0 || a_valid !== 1'b0 || a_cur !== 3'd0 || a_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: y=%b v=%b cur=%0d wrap=%b want all 0", a_y, a_valid, a_cur, a_wrap);
        end
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            exp_sel = (e < 4) ? 3'd0 : 3'd1;
            n_checks++;
            if (a_cur !== exp_sel || a_valid !== 1'b1 || a_y !== 1'b1) begin
                n_fail++;
                $display("FAIL areset_restart[%0d]: cur=%0d v=%b y=%b want cur=%0d v=1 y=1", e, a_cur, a_valid, a_y, exp_sel);
            end
        end
    endtask

    task automatic test_mode_toggle;
        logic [2:0] exp_sel;
        logic       exp_wrap;
        a_mode = 1'b1;
        a_load = 1'b0;
        a_din  = 8'b0100_0000;
        do_reset();
        for (int e = 1; e <= 14; e++) tick();
        n_checks++;
        if (a_cur !== 3'd3) begin
            n_fail++;
            $display("FAIL toggle_setup: cur=%0d want 3", a_cur);
        end
        a_mode = 1'b0;
        a_sel  = 3'd6;
        tick();
        n_checks++;
        if (a_cur !== 3'd6 || a_y !== 1'b1 || a_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_manual: cur=%0d y=%b v=%b want 6 1 1", a_cur, a_y, a_valid);
        end
        a_mode = 1'b1;
        a_sel  = 3'd1;
        for (int m = 1; m <= 9; m++) begin
            tick();
            exp_sel  = (m < 4) ? 3'd6 : ((m < 8) ? 3'd7 : 3'd0);
            exp_wrap = (m == 8);
            n_checks++;
            if (a_cur !== exp_sel || a_wrap !== exp_wrap) begin
                n_fail++;
                $display("FAIL toggle_resume[%0d]: cur=%0d wrap=%b want cur=%0d wrap=%b", m, a_cur, a_wrap, exp_sel, exp_wrap);
            end
        end
    endtask

    task automatic test_dwell_one;
        logic [1:0] exp_sel;
        logic [1:0] exp_y;
        c_din  = {2'd3, 2'd2, 2'd1};
        c_mode = 1'b1;
        c_load = 1'b0;
        do_reset();
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_sel = 2'(e % 3);
            exp_y   = exp_sel + 2'd1;
            n_checks++;
            if (c_cur !== exp_sel || c_y !== exp_y || c_wrap !== (e % 3 == 0)) begin
                n_fail++;
                $display("FAIL dwell1[%0d]: cur=%0d y=%0d wrap=%b want cur=%0d y=%0d wrap=%b", e, c_cur, c_y, c_wrap, exp_sel, exp_y, (e % 3 == 0));
            end
        end
        c_mode = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        a_din  = '0; a_sel = '0; a_mode = 1'b0; a_load = 1'b0;
        b_din  = '0; b_sel = '0; b_mode = 1'b0; b_load = 1'b0;
        c_din  = '0; c_sel = '0; c_mode = 1'b0; c_load = 1'b0;
        test_reset();
        test_manual_sweep();
        test_scan_dwell();
        test_load_collision();
        test_illegal_select();
        test_async_reset();
        test_mode_toggle();
        test_dwell_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised, registered N-channel multiplexer with a manual-select mode and an automatic round-robin scan mode. It is the next generation of the team's 8:1 combinational mux. It adds configurable channel count and width, one-cycle registered output with a valid flag, and a dwell-timed channel scanner with a wrap pulse. It sits between a bank of parallel sources and a single-lane consumer (monitor, serialiser, debug probe).

## Interface
- `WIDTH`, default 1: bits per channel.
- `CHANNELS`, default 8: number of input channels, 2..256, need not be a power of two.
- `SEL_W`, default 3: select width; must satisfy 2^SEL_W >= CHANNELS.
- `DWELL`, default 4: cycles each channel is held in scan mode, >= 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `din`, in, CHANNELS*WIDTH: packed channel data; channel k is `din[k*WIDTH +: WIDTH]`.
- `sel`, in, SEL_W: channel select in manual mode; start channel on `load` in scan mode.
- `mode`, in, 1: 0 = MANUAL, 1 = SCAN; level-sensitive.
- `load`, in, 1: in SCAN, restart the scan at `sel`; ignored in MANUAL.
- `y`, out, WIDTH: registered selected channel data.
- `y_valid`, out, 1: `y` holds data from a legal channel.
- `cur_sel`, out, SEL_W: channel index that produced the current `y`.
- `wrap`, out, 1: one-cycle pulse when the scan advances from channel CHANNELS-1 to channel 0.

## Operation
- State register `st` ∈ {MANUAL, SCAN}. Each edge, `st <= mode ? SCAN : MANUAL`.
- Dwell counter `cnt`, range 0..DWELL-1, width $clog2(DWELL) (minimum 1).
- Reset values (async, immediate): `y`=0, `y_valid`=0, `cur_sel`=0, `wrap`=0, `cnt`=0, `st`=MANUAL.

MANUAL (the `mode`=0 branch is evaluated each cycle):
- `sel` < CHANNELS:
  - `y <= din[sel]`, `y_valid <= 1`, `cur_sel <= sel`.
- `sel` >= CHANNELS:
  - `y <= 0`, `y_valid <= 0`, `cur_sel <= sel`.
- In both cases, `cnt <= 0` and `wrap <= 0`.

SCAN (`mode`=1), with `y <= din[next cur_sel]` and `y_valid <= 1` every cycle. Priority order:
1. `load` with `sel` < CHANNELS:
   - `cur_sel <= sel`, `cnt <= 0`, `wrap <= 0`.
   - Load wins over dwell expiry.
2. `load` with an illegal `sel`:
   - Load is ignored and the cycle is treated as case 3 or 4.
3. `cnt` == DWELL-1:
   - `cnt <= 0`.
   - `cur_sel <= (cur_sel == CHANNELS-1) ? 0 : cur_sel+1`.
   - `wrap <= 1` only when wrapping to 0.
4. Otherwise:
   - `cnt <= cnt+1`, `cur_sel` holds, `wrap <= 0`.

Mode transitions and edge cases:
- MANUAL→SCAN: scan starts from the current `cur_sel` with `cnt`=0.
  - If `cur_sel` is illegal, it is forced to 0 on the first SCAN cycle.
- SCAN→MANUAL: takes effect on the first edge with `mode`=0; `cnt` clears.
- DWELL=1: the channel advances every cycle.
- CHANNELS=1: `cur_sel` stays 0 and `wrap` pulses on every dwell expiry.
- `y` is always consistent with `cur_sel`: both update on the same edge.

## Timing
- Latency is 1 cycle from `din`/`sel` sampled at edge n to `y`/`y_valid`/`cur_sel` after edge n.
- `din` changes while a channel is held in scan appear on `y` one cycle later; data is resampled every cycle, not latched at channel entry.
- `wrap` asserts together with the first `y` of channel 0 and lasts exactly 1 cycle.
- `rst` asserted mid-scan:
  - Outputs clear immediately, without waiting for a clock edge.
  - After deassertion, the first edge follows `mode`; the scan restarts from channel 0.
- No combinational path from any input to any output.

## Test plan
1. **Manual sweep.** Setup: CHANNELS=8, WIDTH=1, `din`=8'b10101010, `mode`=0; drive `sel`=0..7, one per cycle. Required: `y` = 0,1,0,1,0,1,0,1, each one cycle after its `sel`, with `y_valid`=1 and `cur_sel` tracking `sel`.
2. **Scan dwell and wrap.** Setup: DWELL=4, `mode`=1 from reset. Required:
   - `cur_sel` holds each of 0..7 for exactly 4 cycles.
   - `wrap`=1 for one cycle only, when `cur_sel` returns to 0 after 32 cycles.
   - `y` follows `din` bit `cur_sel`.
3. **Load vs. expiry collision.** Setup: scanning, `cur_sel`=7, `cnt`=3; pulse `load` with `sel`=2. Required: next `cur_sel`=2, `cnt`=0, `wrap`=0, and channel 2 held for 4 cycles.
4. **Illegal select.** Setup: CHANNELS=6, SEL_W=3, `mode`=0, `sel`=7. Required: `y`=0 and `y_valid`=0. Then switching to `mode`=1 gives `cur_sel`=0 and `y_valid`=1. A `load` with `sel`=6 in scan is ignored.
5. **Async reset mid-scan.** Setup: assert `rst` between edges while `cur_sel`=5. Required: `y`, `y_valid`, `cur_sel`, `wrap` read 0 before the next edge; after release with `mode`=1, the scan restarts at 0.
6. **Mode toggle.** Sequence: SCAN at `cur_sel`=3, `cnt`=2 → `mode`=0 with `sel`=6 → `mode`=1. Required: MANUAL shows channel 6 after one cycle; scan resumes at 6 with a full 4-cycle dwell.
